// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Multi-cycle instruction sequencer. Each instruction walks through
// FETCH/DECODE/EXEC/MEM/WB and the unit drives the datapath strobes for the
// current step. Instruction and data accesses share one memory port handshaked
// with o_mem_req / i_mem_ready, guarded by a wait timeout. Illegal opcodes and
// memory timeouts park the unit in a sticky FAULT state until reset.
//
// Ports
//   i_clk, i_rst_n      clock (rising edge), async active-low reset
//   i_opcode            IR opcode field, valid from DECODE onward
//   i_zero              ALU zero flag, consumed in EXEC
//   i_mem_ready         memory access completes this cycle
//   o_mem_req/o_mem_we  memory request / store qualifier
//   o_iord              memory address select (0 = PC, 1 = ALU result)
//   o_byte_op           byte-wide load/store
//   o_ir_write          load IR
//   o_pc_write/o_pc_src PC update and source (0 = PC+4, 1 = branch, 2 = jump)
//   o_reg_dst           write rd (1) or rt (0)
//   o_alu_src           ALU B operand is immediate (1) or register (0)
//   o_alu_op            ALU operation code
//   o_reg_write         register file write
//   o_mem_to_reg        write-back data from memory
//   o_move              move write-back path
//   o_link              jal writes return address to $31
//   o_state             current state encoding
//   o_fault             sticky fault flag
//   o_instr_retired     one-cycle pulse per completed instruction
//   o_retired_count     wrapping retired-instruction count
//
// state  | meaning
// IDLE   | out of reset, go fetch next cycle
// FETCH  | read instruction at PC, load IR and PC+4 on ready
// DECODE | capture opcode, finish jumps, reject illegal opcodes
// EXEC   | ALU step; branches resolve and retire here
// MEM    | data access for loads/stores
// WB     | register file write-back
// FAULT  | illegal opcode or memory timeout; left only by reset
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int TIMEOUT  = 15,
    parameter int TO_W     = 4,
    parameter int CNT_W    = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_zero,
    input  logic                i_mem_ready,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic                o_iord,
    output logic                o_byte_op,
    output logic                o_ir_write,
    output logic                o_pc_write,
    output logic [1:0]          o_pc_src,
    output logic                o_reg_dst,
    output logic                o_alu_src,
    output logic [2:0]          o_alu_op,
    output logic                o_reg_write,
    output logic                o_mem_to_reg,
    output logic                o_move,
    output logic                o_link,
    output logic [2:0]          o_state,
    output logic                o_fault,
    output logic                o_instr_retired,
    output logic [CNT_W-1:0]    o_retired_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_SUBI = 6'b000011;
    localparam logic [5:0] OP_ANDI = 6'b000100;
    localparam logic [5:0] OP_ORI  = 6'b000101;
    localparam logic [5:0] OP_SLTI = 6'b000111;
    localparam logic [5:0] OP_LW   = 6'b001000;
    localparam logic [5:0] OP_LB   = 6'b001001;
    localparam logic [5:0] OP_SW   = 6'b010000;
    localparam logic [5:0] OP_SB   = 6'b010001;
    localparam logic [5:0] OP_BEQ  = 6'b100011;
    localparam logic [5:0] OP_BNE  = 6'b100111;
    localparam logic [5:0] OP_MOVE = 6'b100000;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JAL  = 6'b111001;

    // TIMEOUT = 0 disables the wait limit entirely.
    localparam bit              TO_EN     = (TIMEOUT > 0);
    localparam int              TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LAST_I);

    state_t             r_state;
    state_t             w_next;
    logic [5:0]         r_op_q;
    logic [TO_W-1:0]    r_to_cnt;
    logic [CNT_W-1:0]   r_count;

    logic [5:0]         w_opc;
    logic               w_op_hi_set;
    logic               w_legal;
    logic               w_to_expire;
    logic               w_retire;
    logic [2:0]         w_alu_op;
    logic               w_alu_src;
    logic               w_is_r;
    logic               w_is_load;
    logic               w_is_store;
    logic               w_is_byte;
    logic               w_is_move;
    logic               w_is_branch;
    logic               w_is_bne;

    assign w_opc = i_opcode[5:0];

    // Opcodes wider than 6 bits: any set upper bit makes the opcode illegal.
    generate
        if (OPCODE_W > 6) begin : g_hi
            assign w_op_hi_set = |i_opcode[OPCODE_W-1:6];
        end else begin : g_no_hi
            assign w_op_hi_set = 1'b0;
        end
    endgenerate

    always_comb begin
        w_legal = 1'b0;
        case (w_opc)
            OP_R, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_LB,
            OP_SW, OP_SB, OP_BEQ, OP_BNE, OP_MOVE, OP_J, OP_JAL:
                w_legal = !w_op_hi_set;
            default: w_legal = 1'b0;
        endcase
    end

    // Attributes of the captured opcode, used from EXEC onward.
    always_comb begin
        w_alu_op    = 3'b000;
        w_alu_src   = 1'b0;
        w_is_r      = 1'b0;
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_byte   = 1'b0;
        w_is_move   = 1'b0;
        w_is_branch = 1'b0;
        w_is_bne    = 1'b0;
        case (r_op_q)
            OP_R:    begin w_alu_op = 3'b111; w_is_r = 1'b1; end
            OP_ADDI: begin w_alu_op = 3'b101; w_alu_src = 1'b1; end
            OP_SUBI: begin w_alu_op = 3'b110; w_alu_src = 1'b1; end
            OP_ANDI: begin w_alu_op = 3'b000; w_alu_src = 1'b1; end
            OP_ORI:  begin w_alu_op = 3'b001; w_alu_src = 1'b1; end
            OP_SLTI: begin w_alu_op = 3'b100; w_alu_src = 1'b1; end
            OP_LW:   begin w_alu_op = 3'b101; w_alu_src = 1'b1; w_is_load = 1'b1; end
            OP_LB:   begin w_alu_op = 3'b101; w_alu_src = 1'b1; w_is_load = 1'b1; w_is_byte = 1'b1; end
            OP_SW:   begin w_alu_op = 3'b101; w_alu_src = 1'b1; w_is_store = 1'b1; end
            OP_SB:   begin w_alu_op = 3'b101; w_alu_src = 1'b1; w_is_store = 1'b1; w_is_byte = 1'b1; end
            OP_BEQ:  begin w_alu_op = 3'b110; w_is_branch = 1'b1; end
            OP_BNE:  begin w_alu_op = 3'b110; w_is_branch = 1'b1; w_is_bne = 1'b1; end
            OP_MOVE: begin w_alu_op = 3'b000; w_is_move = 1'b1; end
            default: ;
        endcase
    end

    // Ready wins over expiry in the last tolerated cycle.
    assign w_to_expire = TO_EN && !i_mem_ready && (r_to_cnt == TO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_op_q   <= '0;
            r_to_cnt <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op_q <= w_opc;
            end
            // Cleared whenever not waiting, so every FETCH/MEM entry starts at 0.
            if ((r_state == S_FETCH || r_state == S_MEM) && !i_mem_ready) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
            if (w_retire) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_iord       = 1'b0;
        o_byte_op    = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_pc_src     = 2'd0;
        o_reg_dst    = 1'b0;
        o_alu_src    = 1'b0;
        o_alu_op     = 3'b000;
        o_reg_write  = 1'b0;
        o_mem_to_reg = 1'b0;
        o_move       = 1'b0;
        o_link       = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_to_expire) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                if (!w_legal) begin
                    w_next = S_FAULT;
                end else if (w_opc == OP_J || w_opc == OP_JAL) begin
                    o_pc_write  = 1'b1;
                    o_pc_src    = 2'd2;
                    o_reg_write = (w_opc == OP_JAL);
                    o_link      = (w_opc == OP_JAL);
                    w_retire    = 1'b1;
                    w_next      = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                o_alu_op  = w_alu_op;
                o_alu_src = w_alu_src;
                o_reg_dst = w_is_r;
                if (w_is_branch) begin
                    o_pc_src   = 2'd1;
                    o_pc_write = w_is_bne ? !i_zero : i_zero;
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                o_mem_req = 1'b1;
                o_iord    = 1'b1;
                o_mem_we  = w_is_store;
                o_byte_op = w_is_byte;
                if (i_mem_ready) begin
                    w_retire = w_is_store;
                    w_next   = w_is_store ? S_FETCH : S_WB;
                end else if (w_to_expire) begin
                    w_next = S_FAULT;
                end
            end
            S_WB: begin
                o_alu_op     = w_alu_op;
                o_alu_src    = w_alu_src;
                o_reg_dst    = w_is_r;
                o_reg_write  = 1'b1;
                o_mem_to_reg = w_is_load;
                o_move       = w_is_move;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FAULT;
        endcase
    end

    assign o_state         = r_state;
    assign o_fault         = (r_state == S_FAULT);
    assign o_instr_retired = w_retire;
    assign o_retired_count = r_count;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle combinational decoder.
- Sequences each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB and drives per-state datapath strobes.
- Handshakes with a shared instruction/data memory (mem_req/mem_ready), with a parametrised wait timeout.
- Raises a sticky fault on illegal opcodes or memory timeout, and counts retired instructions.

Parameters:
- OPCODE_W, 6: opcode width; decode compares the low 6 bits, and any set upper bit is illegal.
- TIMEOUT, 15: consecutive not-ready cycles tolerated in FETCH/MEM; 0 disables the timeout.
- TO_W, 4: timeout counter width; must hold TIMEOUT.
- CNT_W, 32: retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  instruction opcode field from IR, valid from DECODE onward.
- zero  in  1  ALU zero flag, used in EXEC.
- mem_ready  in  1  memory access complete this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  store request; valid only with mem_req.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result.
- byte_op  out  1  byte-wide load/store.
- ir_write  out  1  load IR.
- pc_write  out  1  update PC.
- pc_src  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target.
- reg_dst  out  1  destination register: rd (1) or rt (0).
- alu_src  out  1  ALU B operand: immediate (1) or register (0).
- alu_op  out  3  ALU operation code.
- reg_write  out  1  register file write.
- mem_to_reg  out  1  write-back data from memory.
- move  out  1  move write-back path.
- link  out  1  jal writes return address to $31.
- state  out  3  current state encoding.
- fault  out  1  sticky fault flag.
- instr_retired  out  1  one-cycle pulse per completed instruction.
- retired_count  out  CNT_W  retired-instruction count; wraps.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7.
- Reset (async, any time including mid-access):
  - state=IDLE; fault, retired_count, timeout counter and op_q cleared.
  - All strobes are 0 in IDLE.
  - IDLE always proceeds to FETCH on the next clock.
- Strobes not listed for a state are 0. alu_op, alu_src and reg_dst are driven from op_q in EXEC and WB.
- FETCH:
  - mem_req=1, iord=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
- DECODE:
  - op_q <= opcode, registered once per instruction.
  - Illegal opcode -> FAULT.
  - j (111000): pc_write=1, pc_src=2, retire -> FETCH.
  - jal (111001): pc_write=1, pc_src=2, reg_write=1, link=1, retire -> FETCH.
  - All other legal opcodes -> EXEC.
- Legal opcodes: 000000 R, 000010 addi, 000011 subi, 000100 andi, 000101 ori, 000111 slti, 001000 lw, 001001 lb, 010000 sw, 010001 sb, 100011 beq, 100111 bne, 100000 move, 111000 j, 111001 jal.
- alu_op encoding: R=111; addi/lw/lb/sw/sb=101; subi/beq/bne=110; andi=000; ori=001; slti=100; move=000.
- alu_src=1 for addi, subi, andi, ori, slti and all loads/stores.
- EXEC:
  - beq: pc_write=zero, pc_src=1, retire -> FETCH. bne: same with pc_write=!zero.
  - lw/lb/sw/sb -> MEM. All others -> WB.
- MEM:
  - mem_req=1, iord=1; mem_we=1 for sw/sb; byte_op=1 for lb/sb.
  - On mem_ready: stores retire -> FETCH; loads -> WB.
  - Request signals must stay stable while mem_ready is low.
- WB:
  - reg_write=1; reg_dst=1 for R only; mem_to_reg=1 for lw/lb; move=1 for move.
  - Retire -> FETCH.
- Timeout (FETCH and MEM only):
  - Counter clears on entry to FETCH/MEM and increments each cycle with mem_ready=0.
  - mem_ready=0 while counter==TIMEOUT-1 -> FAULT.
  - mem_ready=1 in that same cycle completes normally; ready has priority.
  - TIMEOUT=0: wait indefinitely.
- Retire:
  - instr_retired=1 for exactly the cycle of the retiring transition.
  - retired_count increments on the next edge and wraps from 2^CNT_W-1 to 0.
- FAULT: fault=1, all strobes 0, no further transitions. Exit only via rst_n.
- Latencies with mem_ready always high: R/I/move 4 cycles; load 5; store 4; branch 3; j/jal 2.

Test Plan:
- Reset release, mem_ready=1, opcode=000000 -> state 0,1,2,3,5,1; reg_write and reg_dst high in WB only; alu_op=111 in EXEC; instr_retired pulses once; retired_count=1.
- lb (001001), mem_ready low 3 cycles in MEM -> mem_req/iord/byte_op held 4 cycles, mem_we=0; then WB with mem_to_reg=1, reg_write=1.
- beq with zero=1 then zero=0, then bne with zero=0 -> pc_write=1, pc_src=1 in EXEC for beq/zero=1 and bne/zero=0; pc_write=0 for beq/zero=0; each takes 3 cycles.
- jal (111001) -> in DECODE: pc_write=1, pc_src=2, reg_write=1, link=1; back in FETCH next cycle.
- TIMEOUT=15, mem_ready held low in FETCH -> FAULT entered after the 15th low cycle, fault sticky; mem_ready rising at cycle 15 instead -> no fault.
- Illegal opcode 111111 -> FAULT from DECODE; rst_n pulsed mid-FAULT and mid-MEM -> state=0 immediately, all outputs 0, retired_count=0.
